// File: rtl/stack_ptr_ctr_pkg.sv
// -----------------------------------------------------------------------------
// stack_ptr_ctr_pkg
//   Shared definitions for the data-memory stack pointer: the SP operation
//   encoding used between the priority decode and the next-value calculator,
//   the default SP width also used by the data-memory address mux, and a
//   helper that turns the raw command strobes into one operation code.
// -----------------------------------------------------------------------------
package stack_ptr_ctr_pkg;

   localparam int unsigned SP_WIDTH_DEFAULT = 10;

   typedef logic [1:0] sp_op_t;

   localparam sp_op_t OP_HOLD = 2'd0;
   localparam sp_op_t OP_PUSH = 2'd1;
   localparam sp_op_t OP_POP  = 2'd2;
   localparam sp_op_t OP_LOAD = 2'd3;

   // Load wins over push/pop; push and pop together cancel into a hold.
   function automatic sp_op_t decode_op(input logic ld_en, input logic push,
                                        input logic pop);
      sp_op_t op;
      op = OP_HOLD;
      if (ld_en)             op = OP_LOAD;
      else if (push && !pop) op = OP_PUSH;
      else if (pop && !push) op = OP_POP;
      return op;
   endfunction

endpackage

// File: rtl/stack_ptr_ctr_if.sv
// -----------------------------------------------------------------------------
// stack_ptr_ctr_if
//   Command/status bundle of the stack pointer counter.
//   master drives: push, pop, ld_en, ld_val, wrap, err_clr
//   slave drives : sp, full, empty, ovf, unf (and hwm when STACK_PTR_HWM_EN)
//
//   Handshake: there is no valid/ready pair. Every command strobe is a level
//   sampled on each falling clk edge and is accepted unconditionally on that
//   edge (no backpressure); status outputs are stable between falling edges.
// -----------------------------------------------------------------------------
interface stack_ptr_ctr_if
   import stack_ptr_ctr_pkg::*;
#(
   parameter int unsigned WIDTH = SP_WIDTH_DEFAULT
);
   logic             push;
   logic             pop;
   logic             ld_en;
   logic [WIDTH-1:0] ld_val;
   logic             wrap;
   logic             err_clr;
   logic [WIDTH-1:0] sp;
   logic             full;
   logic             empty;
   logic             ovf;
   logic             unf;
`ifdef STACK_PTR_HWM_EN
   logic [WIDTH-1:0] hwm;
`endif

   modport master (
      output push, pop, ld_en, ld_val, wrap, err_clr,
`ifdef STACK_PTR_HWM_EN
      input  hwm,
`endif
      input  sp, full, empty, ovf, unf
   );

   modport slave (
      input  push, pop, ld_en, ld_val, wrap, err_clr,
`ifdef STACK_PTR_HWM_EN
      output hwm,
`endif
      output sp, full, empty, ovf, unf
   );

endinterface

// File: rtl/stack_ptr_ctr_sp_next_calc.sv
// -----------------------------------------------------------------------------
// stack_ptr_ctr_sp_next_calc
//   Combinational next-SP calculator for a full-descending stack.
//   in : sp (current), op (OP_*), wrap (0 saturate / 1 wrap), ld_val
//   out: next_sp, ovf_set (push/load below BOTTOM), unf_set (pop/load above TOP)
//   All bound arithmetic is done in WIDTH+1 bits so a push below zero or a
//   pop past 2^WIDTH-1 is detected rather than silently wrapping.
// -----------------------------------------------------------------------------
module stack_ptr_ctr_sp_next_calc
   import stack_ptr_ctr_pkg::*;
#(
   parameter int unsigned      WIDTH  = SP_WIDTH_DEFAULT,
   parameter logic [WIDTH-1:0] TOP    = {WIDTH{1'b1}},
   parameter logic [WIDTH-1:0] BOTTOM = '0,
   parameter int unsigned      STEP   = 1
) (
   input  logic [WIDTH-1:0] sp,
   input  sp_op_t           op,
   input  logic             wrap,
   input  logic [WIDTH-1:0] ld_val,
   output logic [WIDTH-1:0] next_sp,
   output logic             ovf_set,
   output logic             unf_set
);

   localparam logic [WIDTH:0] TOP_X  = {1'b0, TOP};
   localparam logic [WIDTH:0] BOT_X  = {1'b0, BOTTOM};
   localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);
   localparam logic [WIDTH:0] ONE_X  = (WIDTH+1)'(1);

   logic [WIDTH:0] sp_x;
   logic [WIDTH:0] dec_x;
   logic [WIDTH:0] inc_x;
   logic [WIDTH:0] wrap_dn_x;
   logic [WIDTH:0] wrap_up_x;
   logic           push_past;
   logic           pop_past;

   assign sp_x  = {1'b0, sp};
   assign dec_x = sp_x - STEP_X;
   assign inc_x = sp_x + STEP_X;

   // Compare before subtracting so a borrow below zero cannot fool the check.
   assign push_past = (sp_x < (BOT_X + STEP_X));
   assign pop_past  = (inc_x > TOP_X);

   // TOP-(BOTTOM-(sp-STEP))+1 rearranged so no intermediate goes negative.
   assign wrap_dn_x = sp_x + TOP_X + ONE_X - BOT_X - STEP_X;
   // BOTTOM+((sp+STEP)-TOP)-1; inc_x > TOP here, so the difference is >= 0.
   assign wrap_up_x = inc_x - TOP_X - ONE_X + BOT_X;

   always_comb begin
      next_sp = sp;
      ovf_set = 1'b0;
      unf_set = 1'b0;
      case (op)
         OP_LOAD: begin
            if (ld_val < BOTTOM)   ovf_set = 1'b1;
            else if (ld_val > TOP) unf_set = 1'b1;
            else                   next_sp = ld_val;
         end
         OP_PUSH: begin
            if (push_past) begin
               ovf_set = 1'b1;
               next_sp = wrap ? wrap_dn_x[WIDTH-1:0] : BOTTOM;
            end else begin
               next_sp = dec_x[WIDTH-1:0];
            end
         end
         OP_POP: begin
            if (pop_past) begin
               unf_set = 1'b1;
               next_sp = wrap ? wrap_up_x[WIDTH-1:0] : TOP;
            end else begin
               next_sp = inc_x[WIDTH-1:0];
            end
         end
         default: next_sp = sp;
      endcase
   end

endmodule

// File: rtl/stack_ptr_ctr.sv
// -----------------------------------------------------------------------------
// stack_ptr_ctr
//   Stack-pointer counter for the data-memory side of the MIPS core
//   (full-descending: push decrements, pop increments). State changes on the
//   FALLING clk edge to line up with data-memory timing.
//   clk, rst : clock and synchronous active-high reset (sampled on falling edge)
//   bus      : stack_ptr_ctr_if.slave - commands in, sp/full/empty/ovf/unf out
//   Optional : define STACK_PTR_HWM_EN to add bus.hwm, the lowest SP reached
//              since reset or the last err_clr (i.e. the maximum stack depth).
// -----------------------------------------------------------------------------
module stack_ptr_ctr
   import stack_ptr_ctr_pkg::*;
#(
   parameter int unsigned      WIDTH  = SP_WIDTH_DEFAULT,
   parameter logic [WIDTH-1:0] TOP    = {WIDTH{1'b1}},
   parameter logic [WIDTH-1:0] BOTTOM = '0,
   parameter int unsigned      STEP   = 1
) (
   input logic            clk,
   input logic            rst,
   stack_ptr_ctr_if.slave bus
);

   sp_op_t           op;
   logic [WIDTH-1:0] sp_q, sp_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic             ovf_set;
   logic             unf_set;

   assign op = decode_op(bus.ld_en, bus.push, bus.pop);

   stack_ptr_ctr_sp_next_calc #(
      .WIDTH  (WIDTH),
      .TOP    (TOP),
      .BOTTOM (BOTTOM),
      .STEP   (STEP)
   ) u_next (
      .sp      (sp_q),
      .op      (op),
      .wrap    (bus.wrap),
      .ld_val  (bus.ld_val),
      .next_sp (sp_d),
      .ovf_set (ovf_set),
      .unf_set (unf_set)
   );

   // A new error on the same edge as err_clr keeps its flag set.
   always_comb begin
      ovf_d = ovf_set | (ovf_q & ~bus.err_clr);
      unf_d = unf_set | (unf_q & ~bus.err_clr);
   end

   always_ff @(negedge clk) begin
      if (rst) begin
         sp_q  <= TOP;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         sp_q  <= sp_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   assign bus.sp    = sp_q;
   assign bus.full  = (sp_q == BOTTOM);
   assign bus.empty = (sp_q == TOP);
   assign bus.ovf   = ovf_q;
   assign bus.unf   = unf_q;

`ifdef STACK_PTR_HWM_EN
   logic [WIDTH-1:0] hwm_q, hwm_d;
   logic [WIDTH-1:0] hwm_base;

   // err_clr restarts tracking from the current SP; the new SP (after a push,
   // pop or load) then replaces it if it is lower.
   always_comb begin
      hwm_base = bus.err_clr ? sp_q : hwm_q;
      hwm_d    = (sp_d < hwm_base) ? sp_d : hwm_base;
   end

   always_ff @(negedge clk) begin
      if (rst) hwm_q <= TOP;
      else     hwm_q <= hwm_d;
   end

   assign bus.hwm = hwm_q;
`endif

endmodule

// File: tb/tb_stack_ptr_ctr.sv
// -----------------------------------------------------------------------------
// tb_stack_ptr_ctr
//   Directed bench for stack_ptr_ctr. Three instances cover the parameter
//   corners: A (TOP=0x3FF, BOTTOM=0, STEP=1), B (STEP=4), C (TOP=0x200,
//   BOTTOM=0x010). Inputs change 1 time unit after the rising edge, the DUT
//   updates on the falling edge, and the monitor compares on the next rising
//   edge against expectations queued by the driver.
// -----------------------------------------------------------------------------
module tb_stack_ptr_ctr;
   import stack_ptr_ctr_pkg::*;

   localparam int W = 10;
   localparam logic [W-1:0] A_TOP = 10'h3FF, A_BOT = 10'h000;
   localparam logic [W-1:0] B_TOP = 10'h3FF, B_BOT = 10'h000;
   localparam logic [W-1:0] C_TOP = 10'h200, C_BOT = 10'h010;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0;
   always #5 clk = ~clk;

   stack_ptr_ctr_if #(.WIDTH(W)) if_a ();
   stack_ptr_ctr_if #(.WIDTH(W)) if_b ();
   stack_ptr_ctr_if #(.WIDTH(W)) if_c ();

   stack_ptr_ctr #(.WIDTH(W), .TOP(A_TOP), .BOTTOM(A_BOT), .STEP(1))
      dut_a (.clk(clk), .rst(rst_a), .bus(if_a.slave));
   stack_ptr_ctr #(.WIDTH(W), .TOP(B_TOP), .BOTTOM(B_BOT), .STEP(4))
      dut_b (.clk(clk), .rst(rst_b), .bus(if_b.slave));
   stack_ptr_ctr #(.WIDTH(W), .TOP(C_TOP), .BOTTOM(C_BOT), .STEP(1))
      dut_c (.clk(clk), .rst(rst_c), .bus(if_c.slave));

   // ---------------- scoreboard ----------------
   typedef struct packed {
      logic [1:0]   dut;
      logic [W-1:0] sp;
      logic         ovf;
      logic         unf;
      logic [W-1:0] hwm;
      logic [7:0]   tag;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   vec_n  = 0;

   // ---------------- driver tasks ----------------
   task automatic idle_all();
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
      if_a.push = 0; if_a.pop = 0; if_a.ld_en = 0; if_a.ld_val = '0; if_a.wrap = 0; if_a.err_clr = 0;
      if_b.push = 0; if_b.pop = 0; if_b.ld_en = 0; if_b.ld_val = '0; if_b.wrap = 0; if_b.err_clr = 0;
      if_c.push = 0; if_c.pop = 0; if_c.ld_en = 0; if_c.ld_val = '0; if_c.wrap = 0; if_c.err_clr = 0;
   endtask

   // One falling edge of stimulus on instance d, plus the state expected after it.
   task automatic step(input int d, input logic r, input logic p, input logic q,
                       input logic l, input logic [W-1:0] lv, input logic w,
                       input logic c, input logic [W-1:0] e_sp, input logic e_ovf,
                       input logic e_unf, input logic [W-1:0] e_hwm);
      exp_t e;
      @(posedge clk);
      #1;
      idle_all();
      case (d)
         0: begin rst_a = r; if_a.push = p; if_a.pop = q; if_a.ld_en = l;
                  if_a.ld_val = lv; if_a.wrap = w; if_a.err_clr = c; end
         1: begin rst_b = r; if_b.push = p; if_b.pop = q; if_b.ld_en = l;
                  if_b.ld_val = lv; if_b.wrap = w; if_b.err_clr = c; end
         default: begin rst_c = r; if_c.push = p; if_c.pop = q; if_c.ld_en = l;
                  if_c.ld_val = lv; if_c.wrap = w; if_c.err_clr = c; end
      endcase
      e.dut = 2'(d); e.sp = e_sp; e.ovf = e_ovf; e.unf = e_unf; e.hwm = e_hwm;
      e.tag = 8'(vec_n);
      vec_n++;
      exp_q.push_back(e);
   endtask

   // ---------------- monitor ----------------
   always @(posedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t         e;
         logic [W-1:0] g_sp, g_hwm, top, bot;
         logic         g_full, g_empty, g_ovf, g_unf, e_full, e_empty;
         e = exp_q.pop_front();
         g_hwm = '0;
         case (e.dut)
            2'd0: begin g_sp = if_a.sp; g_full = if_a.full; g_empty = if_a.empty;
                        g_ovf = if_a.ovf; g_unf = if_a.unf; top = A_TOP; bot = A_BOT;
`ifdef STACK_PTR_HWM_EN
                        g_hwm = if_a.hwm;
`endif
                  end
            2'd1: begin g_sp = if_b.sp; g_full = if_b.full; g_empty = if_b.empty;
                        g_ovf = if_b.ovf; g_unf = if_b.unf; top = B_TOP; bot = B_BOT;
`ifdef STACK_PTR_HWM_EN
                        g_hwm = if_b.hwm;
`endif
                  end
            default: begin g_sp = if_c.sp; g_full = if_c.full; g_empty = if_c.empty;
                        g_ovf = if_c.ovf; g_unf = if_c.unf; top = C_TOP; bot = C_BOT;
`ifdef STACK_PTR_HWM_EN
                        g_hwm = if_c.hwm;
`endif
                  end
         endcase
         e_full  = (e.sp == bot);
         e_empty = (e.sp == top);
         checks++;
         if (g_sp !== e.sp || g_full !== e_full || g_empty !== e_empty ||
             g_ovf !== e.ovf || g_unf !== e.unf) begin
            errors++;
            $display("FAIL vec%0d dut%0d: got sp=%h full=%b empty=%b ovf=%b unf=%b, exp sp=%h full=%b empty=%b ovf=%b unf=%b",
                     e.tag, e.dut, g_sp, g_full, g_empty, g_ovf, g_unf,
                     e.sp, e_full, e_empty, e.ovf, e.unf);
         end
`ifdef STACK_PTR_HWM_EN
         checks++;
         if (g_hwm !== e.hwm) begin
            errors++;
            $display("FAIL vec%0d_hwm dut%0d: got hwm=%h, exp hwm=%h", e.tag, e.dut, g_hwm, e.hwm);
         end
`else
         if (g_hwm != '0) $display("note: unexpected hwm value %h", g_hwm);
`endif
      end
   end

   // ---------------- directed vectors ----------------
   //   args: dut, rst, push, pop, ld, ld_val, wrap, clr | exp sp, ovf, unf, hwm
   initial begin
      idle_all();
      // Instance A: TOP=0x3FF BOTTOM=0 STEP=1
      step(0, 1,0,0,0,10'h000,0,0, 10'h3FF,0,0,10'h3FF); // reset
      step(0, 0,1,0,0,10'h000,0,0, 10'h3FE,0,0,10'h3FE); // push
      step(0, 0,1,0,0,10'h000,0,0, 10'h3FD,0,0,10'h3FD); // push
      step(0, 0,1,0,0,10'h000,0,0, 10'h3FC,0,0,10'h3FC); // push
      step(0, 0,0,1,0,10'h000,0,0, 10'h3FD,0,0,10'h3FC); // pop
      step(0, 0,1,1,0,10'h000,0,0, 10'h3FD,0,0,10'h3FC); // push&pop hold
      step(0, 0,0,0,1,10'h001,0,0, 10'h001,0,0,10'h001); // ld 0x001
      step(0, 0,1,0,0,10'h000,0,0, 10'h000,0,0,10'h000); // push -> full
      step(0, 0,1,0,0,10'h000,0,0, 10'h000,1,0,10'h000); // push saturate, ovf
      step(0, 0,0,0,0,10'h000,0,1, 10'h000,0,0,10'h000); // err_clr
      step(0, 0,0,0,1,10'h001,1,0, 10'h001,0,0,10'h000); // ld 0x001
      step(0, 0,1,0,0,10'h000,1,0, 10'h000,0,0,10'h000); // push wrap mode
      step(0, 0,1,0,0,10'h000,1,0, 10'h3FF,1,0,10'h000); // push wraps to TOP
      step(0, 0,0,1,0,10'h000,0,0, 10'h3FF,1,1,10'h000); // pop saturate, unf
      step(0, 0,0,1,0,10'h000,1,0, 10'h000,1,1,10'h000); // pop wraps to BOTTOM
      step(0, 0,1,0,0,10'h000,0,1, 10'h000,1,0,10'h000); // clr + new ovf: ovf wins
      step(0, 0,1,0,1,10'h155,0,0, 10'h155,1,0,10'h000); // ld beats push
      step(0, 1,0,0,1,10'h055,0,0, 10'h3FF,0,0,10'h3FF); // rst beats ld
      step(0, 0,0,0,1,10'h100,0,0, 10'h100,0,0,10'h100); // ld 0x100
      step(0, 0,0,1,0,10'h000,0,0, 10'h101,0,0,10'h100); // pop
      step(0, 0,0,1,0,10'h000,0,0, 10'h102,0,0,10'h100); // pop
      step(0, 1,0,0,0,10'h000,0,0, 10'h3FF,0,0,10'h3FF); // rst mid-run
      step(0, 0,0,0,0,10'h000,0,1, 10'h3FF,0,0,10'h3FF); // clr at empty
      step(0, 0,0,0,0,10'h000,0,0, 10'h3FF,0,0,10'h3FF); // hold
      // Instance B: STEP=4
      step(1, 1,0,0,0,10'h000,0,0, 10'h3FF,0,0,10'h3FF); // reset
      step(1, 0,0,0,1,10'h3FD,0,0, 10'h3FD,0,0,10'h3FD); // ld 0x3FD
      step(1, 0,0,1,0,10'h000,0,0, 10'h3FF,0,1,10'h3FD); // pop past TOP saturates
      step(1, 0,1,0,0,10'h000,0,0, 10'h3FB,0,1,10'h3FB); // push by 4, unf sticky
      step(1, 0,0,0,1,10'h002,0,0, 10'h002,0,1,10'h002); // ld 0x002
      step(1, 0,1,0,0,10'h000,1,0, 10'h3FE,1,1,10'h002); // push wraps: 0x3FE
      step(1, 0,0,1,0,10'h000,1,0, 10'h002,1,1,10'h002); // pop wraps: 0x002
      step(1, 0,0,1,0,10'h000,0,0, 10'h006,1,1,10'h002); // pop in range
      // Instance C: TOP=0x200 BOTTOM=0x010
      step(2, 1,0,0,0,10'h000,0,0, 10'h200,0,0,10'h200); // reset
      step(2, 0,0,0,1,10'h300,0,0, 10'h200,0,1,10'h200); // ld > TOP: hold, unf
      step(2, 0,0,0,1,10'h005,0,0, 10'h200,1,1,10'h200); // ld < BOTTOM: hold, ovf
      step(2, 0,0,0,0,10'h000,0,1, 10'h200,0,0,10'h200); // err_clr
      step(2, 0,0,0,1,10'h011,0,0, 10'h011,0,0,10'h011); // ld 0x011
      step(2, 0,1,0,0,10'h000,0,0, 10'h010,0,0,10'h010); // push -> full at BOTTOM
      step(2, 0,1,0,0,10'h000,1,0, 10'h200,1,0,10'h010); // push wraps to TOP
      step(2, 0,0,1,0,10'h000,1,0, 10'h010,1,1,10'h010); // pop wraps to BOTTOM

      @(posedge clk);
      #1;
      idle_all();
      for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending, exp 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
